mem_cmd_decoder: RTL and testbench

- Downstream of the CPU memory-port wrapper: consumes its mem_cmd_*/mem_rsp_* bus and routes each command to one of two slaves (S0 = RAM, S1 = peripheral block) or to an internal default slave, by address decode.
- Tracks outstanding reads so responses return to the master in order.
- Reports unmapped accesses through a pulse and a saturating counter.
- All slave-side signals use the same cmd/rsp protocol as the master side, so slaves are interchangeable.

---
 rtl/mem_cmd_decoder_pkg.sv | 23 ++
 rtl/mem_cmd_decoder.sv | 139 +++++++++++++
 tb/tb_mem_cmd_decoder.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_cmd_decoder_pkg.sv
// Shared memory-bus definitions: slave target encoding, default memory map
// and the address-match helper used by the command decoder.
package mem_cmd_decoder_pkg;

  typedef enum logic [1:0] {
    TGT_S0  = 2'd0,
    TGT_S1  = 2'd1,
    TGT_DEF = 2'd2
  } target_e;

  localparam logic [31:0] RAM_BASE      = 32'h0000_0000;
  localparam logic [31:0] RAM_MASK      = 32'hFFFF_0000;
  localparam logic [31:0] PERIPH_BASE   = 32'hF000_0000;
  localparam logic [31:0] PERIPH_MASK   = 32'hFF00_0000;
  localparam logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF;

  function automatic logic addr_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/mem_cmd_decoder.sv
// Routes master memory commands to RAM (S0), peripherals (S1) or an internal
// default slave, keeping outstanding reads in order and counting unmapped hits.
module mem_cmd_decoder
  import mem_cmd_decoder_pkg::*;
#(
  parameter logic [31:0] S0_BASE         = RAM_BASE,
  parameter logic [31:0] S0_MASK         = RAM_MASK,
  parameter logic [31:0] S1_BASE         = PERIPH_BASE,
  parameter logic [31:0] S1_MASK         = PERIPH_MASK,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] DEFAULT_RDATA   = UNMAPPED_DATA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_cmd_valid,
  output logic        mem_cmd_ready,
  input  logic        mem_cmd_instr,
  input  logic        mem_cmd_wr,
  input  logic [31:0] mem_cmd_addr,
  input  logic [31:0] mem_cmd_wdata,
  input  logic [3:0]  mem_cmd_be,
  output logic        mem_rsp_ready,
  output logic [31:0] mem_rsp_rdata,
  output logic        s0_cmd_valid,
  input  logic        s0_cmd_ready,
  output logic        s0_cmd_instr,
  output logic        s0_cmd_wr,
  output logic [31:0] s0_cmd_addr,
  output logic [31:0] s0_cmd_wdata,
  output logic [3:0]  s0_cmd_be,
  input  logic        s0_rsp_ready,
  input  logic [31:0] s0_rsp_rdata,
  output logic        s1_cmd_valid,
  input  logic        s1_cmd_ready,
  output logic        s1_cmd_instr,
  output logic        s1_cmd_wr,
  output logic [31:0] s1_cmd_addr,
  output logic [31:0] s1_cmd_wdata,
  output logic [3:0]  s1_cmd_be,
  input  logic        s1_rsp_ready,
  input  logic [31:0] s1_rsp_rdata,
  output logic        decode_err,
  output logic [7:0]  decode_err_cnt
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  target_e    tgt;
  target_e    out_tgt;
  logic [3:0] out_cnt;
  logic       stall;
  logic       rd_accept;
  logic       def_accept;
  logic       rsp_fire;

  assign s0_cmd_instr = mem_cmd_instr;
  assign s0_cmd_wr    = mem_cmd_wr;
  assign s0_cmd_addr  = mem_cmd_addr;
  assign s0_cmd_wdata = mem_cmd_wdata;
  assign s0_cmd_be    = mem_cmd_be;
  assign s1_cmd_instr = mem_cmd_instr;
  assign s1_cmd_wr    = mem_cmd_wr;
  assign s1_cmd_addr  = mem_cmd_addr;
  assign s1_cmd_wdata = mem_cmd_wdata;
  assign s1_cmd_be    = mem_cmd_be;

  // S0 wins when both windows match.
  always_comb begin
    if (addr_hit(mem_cmd_addr, S0_BASE, S0_MASK))      tgt = TGT_S0;
    else if (addr_hit(mem_cmd_addr, S1_BASE, S1_MASK)) tgt = TGT_S1;
    else                                               tgt = TGT_DEF;
  end

  // Reads may only stack up on a single slave so responses stay in order.
  assign stall = mem_cmd_valid &&
                 ((out_cnt != 4'd0 && tgt != out_tgt) ||
                  (!mem_cmd_wr && out_cnt == MAX_CNT));

  always_comb begin
    s0_cmd_valid  = !reset && mem_cmd_valid && tgt == TGT_S0 && !stall;
    s1_cmd_valid  = !reset && mem_cmd_valid && tgt == TGT_S1 && !stall;
    mem_cmd_ready = 1'b0;
    if (!reset && !stall) begin
      case (tgt)
        TGT_S0:  mem_cmd_ready = s0_cmd_ready;
        TGT_S1:  mem_cmd_ready = s1_cmd_ready;
        default: mem_cmd_ready = 1'b1;
      endcase
    end
  end

  assign rd_accept  = mem_cmd_valid && mem_cmd_ready && !mem_cmd_wr;
  assign def_accept = mem_cmd_valid && mem_cmd_ready && tgt == TGT_DEF;

  // Responses from anything other than the tracked slave are dropped.
  always_comb begin
    rsp_fire      = 1'b0;
    mem_rsp_rdata = 32'h0;
    if (!reset && out_cnt != 4'd0) begin
      case (out_tgt)
        TGT_S0: if (s0_rsp_ready) begin
          rsp_fire      = 1'b1;
          mem_rsp_rdata = s0_rsp_rdata;
        end
        TGT_S1: if (s1_rsp_ready) begin
          rsp_fire      = 1'b1;
          mem_rsp_rdata = s1_rsp_rdata;
        end
        TGT_DEF: begin
          rsp_fire      = 1'b1;
          mem_rsp_rdata = DEFAULT_RDATA;
        end
        default: ;
      endcase
    end
  end

  assign mem_rsp_ready = rsp_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_cnt        <= 4'd0;
      out_tgt        <= TGT_S0;
      decode_err     <= 1'b0;
      decode_err_cnt <= 8'd0;
    end else begin
      case ({rd_accept, rsp_fire})
        2'b10:   out_cnt <= out_cnt + 4'd1;
        2'b01:   out_cnt <= out_cnt - 4'd1;
        default: out_cnt <= out_cnt;
      endcase
      if (rd_accept) out_tgt <= tgt;
      decode_err <= def_accept;
      if (def_accept && decode_err_cnt != 8'hFF)
        decode_err_cnt <= decode_err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_mem_cmd_decoder.sv
// Directed-vector bench for mem_cmd_decoder: routing, stalls, ordered
// responses, unmapped handling, reset mid-transaction and counter saturation.
module tb_mem_cmd_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_cmd_valid, mem_cmd_ready, mem_cmd_instr, mem_cmd_wr;
  logic [31:0] mem_cmd_addr, mem_cmd_wdata;
  logic [3:0]  mem_cmd_be;
  logic        mem_rsp_ready;
  logic [31:0] mem_rsp_rdata;
  logic        s0_cmd_valid, s0_cmd_ready, s0_cmd_instr, s0_cmd_wr;
  logic [31:0] s0_cmd_addr, s0_cmd_wdata;
  logic [3:0]  s0_cmd_be;
  logic        s0_rsp_ready;
  logic [31:0] s0_rsp_rdata;
  logic        s1_cmd_valid, s1_cmd_ready, s1_cmd_instr, s1_cmd_wr;
  logic [31:0] s1_cmd_addr, s1_cmd_wdata;
  logic [3:0]  s1_cmd_be;
  logic        s1_rsp_ready;
  logic [31:0] s1_rsp_rdata;
  logic        decode_err;
  logic [7:0]  decode_err_cnt;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mem_cmd_decoder dut (
    .clk(clk), .reset(reset),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_instr(mem_cmd_instr), .mem_cmd_wr(mem_cmd_wr),
    .mem_cmd_addr(mem_cmd_addr), .mem_cmd_wdata(mem_cmd_wdata),
    .mem_cmd_be(mem_cmd_be),
    .mem_rsp_ready(mem_rsp_ready), .mem_rsp_rdata(mem_rsp_rdata),
    .s0_cmd_valid(s0_cmd_valid), .s0_cmd_ready(s0_cmd_ready),
    .s0_cmd_instr(s0_cmd_instr), .s0_cmd_wr(s0_cmd_wr),
    .s0_cmd_addr(s0_cmd_addr), .s0_cmd_wdata(s0_cmd_wdata),
    .s0_cmd_be(s0_cmd_be),
    .s0_rsp_ready(s0_rsp_ready), .s0_rsp_rdata(s0_rsp_rdata),
    .s1_cmd_valid(s1_cmd_valid), .s1_cmd_ready(s1_cmd_ready),
    .s1_cmd_instr(s1_cmd_instr), .s1_cmd_wr(s1_cmd_wr),
    .s1_cmd_addr(s1_cmd_addr), .s1_cmd_wdata(s1_cmd_wdata),
    .s1_cmd_be(s1_cmd_be),
    .s1_rsp_ready(s1_rsp_ready), .s1_rsp_rdata(s1_rsp_rdata),
    .decode_err(decode_err), .decode_err_cnt(decode_err_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be);
    mem_cmd_valid = valid;
    mem_cmd_wr    = wr;
    mem_cmd_addr  = addr;
    mem_cmd_wdata = wdata;
    mem_cmd_be    = be;
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    mem_cmd_instr = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    s0_cmd_ready = 1'b0; s0_rsp_ready = 1'b0; s0_rsp_rdata = 32'h0;
    s1_cmd_ready = 1'b0; s1_rsp_ready = 1'b0; s1_rsp_rdata = 32'h0;
    nextCycle();
    nextCycle();
    reset = 1'b0;

    sample();
    checkOutput("rst_cmd_ready", {31'd0, mem_cmd_ready}, 32'd0);
    checkOutput("rst_rsp_ready", {31'd0, mem_rsp_ready}, 32'd0);
    checkOutput("rst_err", {31'd0, decode_err}, 32'd0);
    checkOutput("rst_err_cnt", {24'd0, decode_err_cnt}, 32'd0);
    checkOutput("rst_out_cnt", {28'd0, dut.out_cnt}, 32'd0);
    nextCycle();

    $display("[TB] S0 read");
    s0_cmd_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
    sample();
    checkOutput("s0rd_valid", {31'd0, s0_cmd_valid}, 32'd1);
    checkOutput("s0rd_s1_valid", {31'd0, s1_cmd_valid}, 32'd0);
    checkOutput("s0rd_ready", {31'd0, mem_cmd_ready}, 32'd1);
    checkOutput("s0rd_addr", s0_cmd_addr, 32'h0000_0010);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    sample();
    checkOutput("s0rd_wait_rsp", {31'd0, mem_rsp_ready}, 32'd0);
    checkOutput("s0rd_out_cnt1", {28'd0, dut.out_cnt}, 32'd1);
    nextCycle();
    s0_rsp_ready = 1'b1; s0_rsp_rdata = 32'h1234_5678;
    sample();
    checkOutput("s0rd_rsp", {31'd0, mem_rsp_ready}, 32'd1);
    checkOutput("s0rd_rdata", mem_rsp_rdata, 32'h1234_5678);
    nextCycle();
    s0_rsp_ready = 1'b0; s0_rsp_rdata = 32'h0;
    sample();
    checkOutput("s0rd_out_cnt0", {28'd0, dut.out_cnt}, 32'd0);
    checkOutput("s0rd_rdata_idle", mem_rsp_rdata, 32'h0);
    nextCycle();

    $display("[TB] S1 write with backpressure");
    s1_cmd_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'hF000_0004, 32'hA5A5_0001, 4'b0011);
    for (int i = 0; i < 3; i++) begin
      sample();
      checkOutput("s1wr_valid_held", {31'd0, s1_cmd_valid}, 32'd1);
      checkOutput("s1wr_ready_low", {31'd0, mem_cmd_ready}, 32'd0);
      checkOutput("s1wr_wdata", s1_cmd_wdata, 32'hA5A5_0001);
      checkOutput("s1wr_be", {28'd0, s1_cmd_be}, 32'h3);
      checkOutput("s1wr_no_rsp", {31'd0, mem_rsp_ready}, 32'd0);
      nextCycle();
    end
    s1_cmd_ready = 1'b1;
    sample();
    checkOutput("s1wr_ready_high", {31'd0, mem_cmd_ready}, 32'd1);
    checkOutput("s1wr_wr_flag", {31'd0, s1_cmd_wr}, 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    sample();
    checkOutput("s1wr_out_cnt", {28'd0, dut.out_cnt}, 32'd0);
    checkOutput("s1wr_no_err", {31'd0, decode_err}, 32'd0);
    nextCycle();

    $display("[TB] unmapped read");
    applyStimulus(1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'hF);
    sample();
    checkOutput("def_ready", {31'd0, mem_cmd_ready}, 32'd1);
    checkOutput("def_s0_valid", {31'd0, s0_cmd_valid}, 32'd0);
    checkOutput("def_s1_valid", {31'd0, s1_cmd_valid}, 32'd0);
    checkOutput("def_rsp_early", {31'd0, mem_rsp_ready}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    sample();
    checkOutput("def_rsp", {31'd0, mem_rsp_ready}, 32'd1);
    checkOutput("def_rdata", mem_rsp_rdata, 32'hDEAD_BEEF);
    checkOutput("def_err", {31'd0, decode_err}, 32'd1);
    checkOutput("def_err_cnt", {24'd0, decode_err_cnt}, 32'd1);
    nextCycle();
    sample();
    checkOutput("def_err_pulse", {31'd0, decode_err}, 32'd0);
    checkOutput("def_rsp_done", {31'd0, mem_rsp_ready}, 32'd0);
    checkOutput("def_out_cnt", {28'd0, dut.out_cnt}, 32'd0);
    nextCycle();

    $display("[TB] cross-slave stall");
    s0_cmd_ready = 1'b1; s1_cmd_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'hF000_0010, 32'h0, 4'hF);
    for (int i = 0; i < 2; i++) begin
      sample();
      checkOutput("xs_s1_valid_stall", {31'd0, s1_cmd_valid}, 32'd0);
      checkOutput("xs_ready_stall", {31'd0, mem_cmd_ready}, 32'd0);
      nextCycle();
    end
    s0_rsp_ready = 1'b1; s0_rsp_rdata = 32'hAAAA_0001;
    sample();
    checkOutput("xs_s0_rsp", {31'd0, mem_rsp_ready}, 32'd1);
    checkOutput("xs_s0_rdata", mem_rsp_rdata, 32'hAAAA_0001);
    checkOutput("xs_s1_still_stall", {31'd0, s1_cmd_valid}, 32'd0);
    nextCycle();
    s0_rsp_ready = 1'b0;
    sample();
    checkOutput("xs_s1_issue", {31'd0, s1_cmd_valid}, 32'd1);
    checkOutput("xs_s1_ready", {31'd0, mem_cmd_ready}, 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    s1_rsp_ready = 1'b1; s1_rsp_rdata = 32'hBBBB_0002;
    sample();
    checkOutput("xs_s1_rsp", {31'd0, mem_rsp_ready}, 32'd1);
    checkOutput("xs_s1_rdata", mem_rsp_rdata, 32'hBBBB_0002);
    nextCycle();
    s1_rsp_ready = 1'b0;

    $display("[TB] outstanding limit");
    applyStimulus(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF);
    sample();
    checkOutput("lim_rd0_ready", {31'd0, mem_cmd_ready}, 32'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h0000_0204, 32'h0, 4'hF);
    sample();
    checkOutput("lim_rd1_ready", {31'd0, mem_cmd_ready}, 32'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h0000_0208, 32'h0, 4'hF);
    for (int i = 0; i < 2; i++) begin
      sample();
      checkOutput("lim_rd2_stall", {31'd0, mem_cmd_ready}, 32'd0);
      checkOutput("lim_rd2_valid", {31'd0, s0_cmd_valid}, 32'd0);
      checkOutput("lim_out_cnt2", {28'd0, dut.out_cnt}, 32'd2);
      nextCycle();
    end
    s0_rsp_ready = 1'b1; s0_rsp_rdata = 32'h0000_0011;
    sample();
    checkOutput("lim_rsp0", mem_rsp_rdata, 32'h0000_0011);
    checkOutput("lim_full_same_cycle", {31'd0, mem_cmd_ready}, 32'd0);
    nextCycle();
    s0_rsp_ready = 1'b0;
    sample();
    checkOutput("lim_rd2_accept", {31'd0, mem_cmd_ready}, 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    s0_rsp_ready = 1'b1; s0_rsp_rdata = 32'h0000_0022;
    sample();
    checkOutput("lim_rsp1", mem_rsp_rdata, 32'h0000_0022);
    nextCycle();
    s0_rsp_rdata = 32'h0000_0033;
    sample();
    checkOutput("lim_rsp2", mem_rsp_rdata, 32'h0000_0033);
    nextCycle();
    s0_rsp_ready = 1'b0; s0_rsp_rdata = 32'h0;
    sample();
    checkOutput("lim_out_cnt0", {28'd0, dut.out_cnt}, 32'd0);
    nextCycle();

    $display("[TB] spurious response");
    s1_rsp_ready = 1'b1; s1_rsp_rdata = 32'hCAFE_0000;
    sample();
    checkOutput("spur_rsp", {31'd0, mem_rsp_ready}, 32'd0);
    checkOutput("spur_rdata", mem_rsp_rdata, 32'h0);
    nextCycle();
    s1_rsp_ready = 1'b0;

    $display("[TB] reset with reads outstanding");
    applyStimulus(1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'hF);
    nextCycle();
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    sample();
    checkOutput("rr_out_cnt2", {28'd0, dut.out_cnt}, 32'd2);
    nextCycle();
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    sample();
    checkOutput("rr_out_cnt0", {28'd0, dut.out_cnt}, 32'd0);
    checkOutput("rr_err_cnt0", {24'd0, decode_err_cnt}, 32'd0);
    nextCycle();
    s0_rsp_ready = 1'b1; s0_rsp_rdata = 32'h5555_AAAA;
    sample();
    checkOutput("rr_late_rsp", {31'd0, mem_rsp_ready}, 32'd0);
    nextCycle();
    s0_rsp_ready = 1'b0;

    $display("[TB] error counter saturation");
    applyStimulus(1'b1, 1'b1, 32'h8000_0000, 32'h1, 4'hF);
    for (int i = 0; i < 260; i++) begin
      if (i == 200) begin
        sample();
        checkOutput("sat_mid_cnt", {24'd0, decode_err_cnt}, 32'd200);
        checkOutput("sat_wr_ready", {31'd0, mem_cmd_ready}, 32'd1);
      end
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    sample();
    checkOutput("sat_cnt", {24'd0, decode_err_cnt}, 32'hFF);
    checkOutput("sat_no_rsp", {31'd0, mem_rsp_ready}, 32'd0);
    nextCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
